// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status encodings, register IDs and the commit FSM state type.
package y86_pkg;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] RAX = 4'h0;
    localparam logic [3:0] RCX = 4'h1;
    localparam logic [3:0] RDX = 4'h2;
    localparam logic [3:0] RBX = 4'h3;
    localparam logic [3:0] RSP = 4'h4;
    localparam logic [3:0] RBP = 4'h5;
    localparam logic [3:0] RSI = 4'h6;
    localparam logic [3:0] RDI = 4'h7;
    localparam logic [3:0] R8  = 4'h8;
    localparam logic [3:0] R9  = 4'h9;
    localparam logic [3:0] R10 = 4'hA;
    localparam logic [3:0] R11 = 4'hB;
    localparam logic [3:0] R12 = 4'hC;
    localparam logic [3:0] R13 = 4'hD;
    localparam logic [3:0] R14 = 4'hE;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } commit_state_t;

endpackage

// File: rtl/reg_array_2w2r.sv
// Register storage with two write ports (M port wins on a shared address) and two async read ports.
module reg_array_2w2r
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREG   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_e,
    input  logic [3:0]        addr_e,
    input  logic [DATA_W-1:0] data_e,
    input  logic              we_m,
    input  logic [3:0]        addr_m,
    input  logic [DATA_W-1:0] data_m,
    input  logic [3:0]        addr_a,
    input  logic [3:0]        addr_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b
);

    localparam logic [3:0] LAST_ID = 4'(NREG - 1);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we_m && addr_m == 4'(i)) begin
                    regs[i] <= data_m;
                end else if (we_e && addr_e == 4'(i)) begin
                    regs[i] <= data_e;
                end
            end
        end
    end

    // IDs past the last register (including RNONE) read as zero.
    always_comb begin
        data_a = '0;
        data_b = '0;
        if (addr_a <= LAST_ID) data_a = regs[addr_a];
        if (addr_b <= LAST_ID) data_b = regs[addr_b];
    end

endmodule

// File: rtl/reg_file_commit.sv
// Y86-64 architectural commit: register file writes, decode read ports with bypass,
// sticky status FSM and retired-instruction counter.
module reg_file_commit
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int BYPASS = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wb_valid_i,
    input  logic [1:0]        stat_i,
    input  logic [3:0]        dstE_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [3:0]        dstM_i,
    input  logic [DATA_W-1:0] valM_i,
    input  logic [3:0]        srcA_i,
    input  logic [3:0]        srcB_i,
    output logic [DATA_W-1:0] valA_o,
    output logic [DATA_W-1:0] valB_o,
    output logic [1:0]        cpu_stat_o,
    output logic              halted_o,
    output logic [63:0]       retired_o
);

    commit_state_t state, next_state;
    logic commit, fault;
    logic [DATA_W-1:0] arr_a, arr_b;

    assign commit = (state == ST_RUN) && wb_valid_i && (stat_i == STAT_AOK);
    assign fault  = (state == ST_RUN) && wb_valid_i && (stat_i != STAT_AOK);

    reg_array_2w2r #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_array (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .we_e   (commit && dstE_i != RNONE),
        .addr_e (dstE_i),
        .data_e (valE_i),
        .we_m   (commit && dstM_i != RNONE),
        .addr_m (dstM_i),
        .data_m (valM_i),
        .addr_a (srcA_i),
        .addr_b (srcB_i),
        .data_a (arr_a),
        .data_b (arr_b)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_RUN;
            cpu_stat_o <= STAT_AOK;
            retired_o  <= '0;
        end else begin
            state <= next_state;
            if (fault) cpu_stat_o <= stat_i;
            if (commit || (fault && stat_i == STAT_HLT)) retired_o <= retired_o + 64'd1;
        end
    end

    always_comb begin
        next_state = state;
        halted_o   = (state == ST_STOP);
        if (fault) next_state = ST_STOP;
    end

    // Forwarding follows write priority: the M result shadows the E result.
    always_comb begin
        valA_o = arr_a;
        valB_o = arr_b;
        if (BYPASS != 0 && commit) begin
            if (dstM_i != RNONE && srcA_i == dstM_i)      valA_o = valM_i;
            else if (dstE_i != RNONE && srcA_i == dstE_i) valA_o = valE_i;
            if (dstM_i != RNONE && srcB_i == dstM_i)      valB_o = valM_i;
            else if (dstE_i != RNONE && srcB_i == dstE_i) valB_o = valE_i;
        end
    end

endmodule
